// File: rtl/bcd_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : bcd_addsub_serial
// Brief    : Digit-serial N-digit BCD adder/subtractor. One decimal-adjusted
//            digit per clock, least-significant digit first. Subtraction is
//            done in ten's complement (nine's complement of b, carry-in 1).
//            Flags operands that contain non-decimal digits.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_addsub_serial #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int               c_W    = 4 * DIGITS;
    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_RUN  = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIGITS - 1);

    logic [1:0]       r_state;
    logic [c_W-1:0]   r_a;
    logic [c_W-1:0]   r_b;
    logic [c_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_sub;
    logic             r_err;
    logic [c_W-1:0]   r_sum;
    logic             r_cout;
    logic             r_err_o;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [c_W-1:0]   w_b_nine;
    logic             w_err_in;
    logic [4:0]       w_r;
    logic [4:0]       w_adj;
    logic [3:0]       w_digit;
    logic             w_cnext;
    logic [c_W-1:0]   w_acc_next;

    // Nine's complement of b and detection of any digit above 9 in a or b
    always_comb begin
        w_b_nine = '0;
        w_err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_b_nine[4*i +: 4] = 4'd9 - b[4*i +: 4];
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                w_err_in = 1'b1;
        end
    end

    // Single decimal-adjust digit cell operating on the current low digits
    always_comb begin
        w_r     = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_c};
        w_adj   = w_r + 5'd6;
        w_digit = w_r[3:0];
        w_cnext = 1'b0;
        if (w_r > 5'd9) begin
            w_digit = w_adj[3:0];
            w_cnext = 1'b1;
        end
    end

    // New digit enters at the MSD end so the LSD ends up in bits [3:0]
    generate
        if (DIGITS == 1) begin : g_acc_one
            assign w_acc_next = w_digit;
        end else begin : g_acc_multi
            assign w_acc_next = {w_digit, r_acc[c_W-1:4]};
        end
    endgenerate

    // Control FSM, operand shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_sub       <= 1'b0;
            r_err       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_err_o     <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= op_sub ? w_b_nine : b;
                        r_c        <= op_sub;
                        r_sub      <= op_sub;
                        r_err      <= w_err_in;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a   <= r_a >> 4;
                    r_b   <= r_b >> 4;
                    r_c   <= w_cnext;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_sum       <= w_acc_next;
                        r_cout      <= w_cnext ^ r_sub;
                        r_err_o     <= r_err;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign err       = r_err_o;

endmodule
`default_nettype wire

// File: tb/tb_bcd_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_addsub_serial
// Brief    : Scoreboard bench for the digit-serial BCD adder/subtractor.
//            Directed operand sets push hand-computed results into a queue;
//            a negedge monitor pops and compares on each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_addsub_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        logic         err_only;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on each rising out_valid, full compare on hand-off
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: out_valid high with sum=%h, no result expected", sum);
            end else begin
                check("latency", cyc - sb[0].acc_cyc, DIGITS);
            end
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("err", {31'b0, err}, {31'b0, e.err});
            if (!e.err_only) begin
                check("sum", {16'b0, sum}, {16'b0, e.sum});
                check("cout", {31'b0, cout}, {31'b0, e.cout});
            end
        end
        prev_valid = out_valid;
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic [W-1:0] es, input logic ec, input logic ee,
                         input logic eo, input logic push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        a        = ia;
        b        = ib;
        op_sub   = isub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        op_sub   = ~isub;
        if (push) sb.push_back('{es, ec, ee, eo, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum", {16'b0, sum}, 32'h0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        // Additions and subtractions
        issue(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-pressure: result held, in_valid ignored while DONE
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_timeout", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_sum", {16'b0, sum}, 32'h6912);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            in_valid = (i == 2 || i == 3);
            a        = 16'h1111;
            b        = 16'h1111;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_hold", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("bp_in_ready_ret", {31'b0, in_ready}, 32'd1);
        drain();

        // Invalid digit then a clean operation
        issue(16'h00A0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        issue(16'h0050, 16'h0050, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset during RUN discards the operation
        issue(16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_sum", {16'b0, sum}, 32'h0);
        check("mid_rst_cout", {31'b0, cout}, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        repeat (10) @(negedge clk);
        issue(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
